spi_master_cmd_frontend: RTL
============================

// Module: spi_master_cmd_frontend
// PURPOSE
//  Command sequencer directly upstream of the SPI master. Accepts one self-describing
//  command (chip select, frequency, packet size, payload, response flag) per transaction.
//  Issues config writes to the master only when the config differs from the last one sent,
//  then issues the payload. Collects the master's received word and returns it on a
//  val/rdy response stream.
// PARAMETERS
//  nbits     34                    max SPI packet width / payload width
//  ncs       1                     number of chip selects
//  logBitsN  $clog2(nbits)+1       packet-size field width
//  logCSN    ncs>1?$clog2(ncs):1   chip-select field width
//  CW (local) 1+logCSN+3+logBitsN+nbits; cmd_msg = {resp_en,cs,freq,size,data}, data in LSBs
// PORTS
//  clk          in   1         clock
//  reset        in   1         reset, synchronous, active-high
//  cmd_val/rdy  in/out 1/1     command handshake
//  cmd_msg      in   CW        command fields as above
//  resp_val/rdy out/in 1/1     response handshake
//  resp_msg     out  nbits     received word, bits >= size forced 0
//  err          out  1         1-cycle pulse: command rejected
//  m_recv_val/rdy/msg     out/in/out 1/1/nbits     master payload interface
//  m_send_val/rdy/msg     in/out/in  1/1/nbits     master received-word interface
//  m_psize_val/rdy/msg    out/in/out 1/1/logBitsN  master packet-size config
//  m_cs_val/rdy/msg       out/in/out 1/1/logCSN    master chip-select config
//  m_freq_val/rdy/msg     out/in/out 1/1/3         master frequency config
// BEHAVIOUR
//  FSM states: IDLE, CFG, XFER, WAIT, RESP. Reset -> IDLE, cache_valid=0.
//  Reset output values: cmd_rdy=1 (IDLE); every other val output, err and m_send_rdy = 0;
//   resp_msg=0.
//  IDLE: cmd_rdy=1; on cmd_val, latch all fields into regs. Next state:
//   - size==0 or size>nbits: err=1 next cycle, no master activity, stay IDLE;
//     command consumed, no response.
//   - cache_valid and {cs,freq,size} equal cached: next XFER.
//   - otherwise: next CFG.
//  CFG: m_psize_val=m_cs_val=m_freq_val=1 with latched fields.
//   Handshake when all three rdy are high. On handshake: update cache, cache_valid=1, -> XFER.
//   The master latches config a cycle before the payload; config and payload are never
//   issued in the same cycle.
//  XFER: m_recv_val=1, m_recv_msg=latched data (unshifted; the master aligns it).
//   On m_recv_rdy -> WAIT.
//  WAIT: m_recv_val=0, m_send_rdy=1. On m_send_val, capture m_send_msg masked to the
//   low 'size' bits. Then -> RESP if resp_en, else -> IDLE.
//  RESP: resp_val=1, resp_msg held stable. On resp_rdy -> IDLE.
//   cmd_rdy=0 in every state except IDLE.
//  Latency (master rdy immediate):
//   - accept at cycle t; m_recv_val at t+2 (config miss) or t+1 (config hit);
//   - resp_val the cycle after the m_send handshake.
//  Backpressure: master rdy low -> hold val and msg unchanged until rdy. resp_rdy low
//   holds RESP indefinitely, with no new command accepted.
//  One transaction is in flight at a time; no queuing.
//  Reset mid-operation:
//   - all state returns to IDLE and cache_valid=0;
//   - the next command always re-issues config;
//   - the master shares this reset.
// TESTING
//  1 reset; cmd cs=0 freq=0 size=8 data=0xA5 resp_en=1, miso looped to mosi ->
//    one 3-way cfg handshake, m_recv_val 2 cycles after accept, resp_msg=0x000000A5.
//  2 repeat cmd with same cfg, data=0x3C -> no cfg val asserted, m_recv_val 1 cycle after
//    accept, resp_msg=0x3C.
//  3 size 8->16 then freq 0->2 -> cfg re-issued each time with the new values;
//    resp_msg=data[15:0].
//  4 resp_en=0, data=0xFF -> m_send_rdy handshake occurs, resp_val never asserted,
//    cmd_rdy=1 next cycle.
//  5 size=0, then size=nbits+1 -> err pulses once per command, m_* val stay 0.
//  6 resp_rdy low 20 cycles -> resp_msg stable, cmd_rdy=0. Reset asserted in XFER ->
//    all val outputs 0 next cycle; the following identical cmd re-issues config.

Source files
------------

// File: rtl/spi_master_cmd_frontend.sv
// Command sequencer in front of the SPI master: sends config only when it changes,
// then the payload, and returns the masked received word on a val/rdy response stream.
module spi_master_cmd_frontend #(
  parameter int nbits    = 34,
  parameter int ncs      = 1,
  parameter int logBitsN = $clog2(nbits) + 1,
  parameter int logCSN   = (ncs > 1) ? $clog2(ncs) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_val,
  output logic                 cmd_rdy,
  input  logic [1+logCSN+3+logBitsN+nbits-1:0] cmd_msg,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [nbits-1:0]     resp_msg,
  output logic                 err,
  output logic                 m_recv_val,
  input  logic                 m_recv_rdy,
  output logic [nbits-1:0]     m_recv_msg,
  input  logic                 m_send_val,
  output logic                 m_send_rdy,
  input  logic [nbits-1:0]     m_send_msg,
  output logic                 m_psize_val,
  input  logic                 m_psize_rdy,
  output logic [logBitsN-1:0]  m_psize_msg,
  output logic                 m_cs_val,
  input  logic                 m_cs_rdy,
  output logic [logCSN-1:0]    m_cs_msg,
  output logic                 m_freq_val,
  input  logic                 m_freq_rdy,
  output logic [2:0]           m_freq_msg
);

  localparam int SIZE_LO = nbits;
  localparam int FREQ_LO = SIZE_LO + logBitsN;
  localparam int CS_LO   = FREQ_LO + 3;
  localparam int RE_BIT  = CS_LO + logCSN;

  typedef enum logic [2:0] {IDLE, CFG, XFER, WAIT, RESP} state_t;

  state_t state, state_next;

  logic [nbits-1:0]    in_data;
  logic [logBitsN-1:0] in_size;
  logic [2:0]          in_freq;
  logic [logCSN-1:0]   in_cs;
  logic                in_resp_en;

  logic [nbits-1:0]    data_r;
  logic [logBitsN-1:0] size_r;
  logic [2:0]          freq_r;
  logic [logCSN-1:0]   cs_r;
  logic                resp_en_r;

  logic [logBitsN-1:0] cache_size;
  logic [2:0]          cache_freq;
  logic [logCSN-1:0]   cache_cs;
  logic                cache_valid;

  logic size_ok, cache_hit, accept, cfg_fire, send_fire;
  logic [nbits-1:0] mask;

  assign in_data    = cmd_msg[SIZE_LO-1:0];
  assign in_size    = cmd_msg[FREQ_LO-1:SIZE_LO];
  assign in_freq    = cmd_msg[CS_LO-1:FREQ_LO];
  assign in_cs      = cmd_msg[RE_BIT-1:CS_LO];
  assign in_resp_en = cmd_msg[RE_BIT];

  assign size_ok   = (in_size != '0) && (in_size <= logBitsN'(nbits));
  assign cache_hit = cache_valid && (in_cs == cache_cs) && (in_freq == cache_freq)
                     && (in_size == cache_size);

  assign m_recv_msg  = data_r;
  assign m_psize_msg = size_r;
  assign m_cs_msg    = cs_r;
  assign m_freq_msg  = freq_r;

  // Keep only the bits the master actually clocked in.
  always_comb begin
    mask = '0;
    for (int i = 0; i < nbits; i++) mask[i] = (logBitsN'(i) < size_r);
  end

  always_comb begin
    state_next  = state;
    cmd_rdy     = 1'b0;
    m_recv_val  = 1'b0;
    m_psize_val = 1'b0;
    m_cs_val    = 1'b0;
    m_freq_val  = 1'b0;
    m_send_rdy  = 1'b0;
    resp_val    = 1'b0;
    accept      = 1'b0;
    cfg_fire    = 1'b0;
    send_fire   = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          accept = 1'b1;
          if (!size_ok)       state_next = IDLE;
          else if (cache_hit) state_next = XFER;
          else                state_next = CFG;
        end
      end
      CFG: begin
        m_psize_val = 1'b1;
        m_cs_val    = 1'b1;
        m_freq_val  = 1'b1;
        if (m_psize_rdy && m_cs_rdy && m_freq_rdy) begin
          cfg_fire   = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        m_recv_val = 1'b1;
        if (m_recv_rdy) state_next = WAIT;
      end
      WAIT: begin
        m_send_rdy = 1'b1;
        if (m_send_val) begin
          send_fire  = 1'b1;
          state_next = resp_en_r ? RESP : IDLE;
        end
      end
      RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cache_valid <= 1'b0;
      cache_size  <= '0;
      cache_freq  <= '0;
      cache_cs    <= '0;
      data_r      <= '0;
      size_r      <= '0;
      freq_r      <= '0;
      cs_r        <= '0;
      resp_en_r   <= 1'b0;
      resp_msg    <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_next;
      err   <= accept && !size_ok;
      if (accept) begin
        data_r    <= in_data;
        size_r    <= in_size;
        freq_r    <= in_freq;
        cs_r      <= in_cs;
        resp_en_r <= in_resp_en;
      end
      if (cfg_fire) begin
        cache_valid <= 1'b1;
        cache_size  <= size_r;
        cache_freq  <= freq_r;
        cache_cs    <= cs_r;
      end
      if (send_fire) resp_msg <= m_send_msg & mask;
    end
  end

endmodule
